req_arbiter: RTL and testbench

- Shares one resource among NUM_REQ requesters.
- Arbitration policy is selectable at run time: fixed priority or round-robin.
- A grant is held for as long as the owner keeps its request high, up to MAX_HOLD cycles; after that the grant is forcibly revoked.
- Sits in front of any shared datapath/register resource; the owner drives the resource while its gnt bit is high.

---
 rtl/arb_pkg.sv | 12 +
 rtl/arb_pick.sv | 38 +++
 rtl/req_arbiter.sv | 77 +++++++
 tb/tb_req_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared state type, mode constants and helpers for req_arbiter
package arb_pkg;
    typedef enum logic [1:0] {IDLE, GRANT, HOLDOFF} arb_state_e;
    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR = 1'b1;
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) if (oh[i]) idx = 4'(i);
        return idx;
    endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational fixed/round-robin winner select; ARB_ONEHOT_CHECK_EN uses unique decisions
module arb_pick import arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [IW-1:0]      ptr,
    input  logic               mode,
    output logic [NUM_REQ-1:0] win,
    output logic [IW-1:0]      idx
);
    logic [NUM_REQ-1:0] cand;
    logic [IW-1:0] j;
    logic hit;
    int start;
    assign cand = req & ~mask;
    // scan from lowest priority to highest so the last hit is the winner
    always_comb begin
`ifdef ARB_ONEHOT_CHECK_EN
        unique if (mode == ARB_RR) start = int'(ptr) + 1;
        else start = 0;
`else
        start = (mode == ARB_RR) ? int'(ptr) + 1 : 0;
`endif
        hit = 1'b0;
        idx = '0;
        j = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = IW'((start + k) % NUM_REQ);
            if (cand[j]) begin
                hit = 1'b1;
                idx = j;
            end
        end
        win = hit ? NUM_REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/req_arbiter.sv
// req_arbiter: fixed/round-robin arbiter with MAX_HOLD timeout; ARB_ONEHOT_CHECK_EN adds grant checks
module req_arbiter import arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W = $clog2(MAX_HOLD + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic                       rr_mode_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       gnt_valid_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id_o,
    output logic                       timeout_o
);
    localparam int IW = $clog2(NUM_REQ);
    arb_state_e state;
    logic [CNT_W-1:0] cnt;
    logic [IW-1:0] ptr, idx;
    logic [NUM_REQ-1:0] mask, win;
    arb_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req(req_i), .mask(mask), .ptr(ptr), .mode(rr_mode_i), .win(win), .idx(idx)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt_o <= '0;
            gnt_valid_o <= 1'b0;
            gnt_id_o <= '0;
            timeout_o <= 1'b0;
            cnt <= '0;
            ptr <= IW'(NUM_REQ - 1);
            mask <= '0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    mask <= '0;
                    cnt <= '0;
                    if (|win) begin
                        state <= GRANT;
                        gnt_o <= win;
                        gnt_valid_o <= 1'b1;
                        gnt_id_o <= idx;
                        ptr <= idx;
                        cnt <= CNT_W'(1);
                    end
                end
                GRANT: begin
                    // release wins over timeout when both land on the same cycle
                    if (!req_i[gnt_id_o] || cnt == CNT_W'(MAX_HOLD)) begin
                        state <= req_i[gnt_id_o] ? HOLDOFF : IDLE;
                        timeout_o <= req_i[gnt_id_o];
                        mask <= req_i[gnt_id_o] ? gnt_o : '0;
                        gnt_o <= '0;
                        gnt_valid_o <= 1'b0;
                        gnt_id_o <= '0;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ARB_ONEHOT_CHECK_EN
    always @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(gnt_o)) else $error("%0t gnt_o not onehot0", $time);
            assert (state != IDLE || (win & ~req_i) == '0) else $error("%0t grant to idle requester", $time);
            assert (gnt_valid_o == |gnt_o) else $error("%0t gnt_valid_o inconsistent", $time);
            assert (onehot_to_idx(16'(gnt_o)) == 4'(gnt_id_o)) else $error("%0t gnt_id_o inconsistent", $time);
        end
    end
`endif
endmodule

// File: tb/tb_req_arbiter.sv
// tb_req_arbiter: directed checks of priority, round-robin, timeout and reset behaviour
module tb_req_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] req_i;
    logic rr_mode_i;
    logic [3:0] gnt_o;
    logic gnt_valid_o;
    logic [1:0] gnt_id_o;
    logic timeout_o;
    int total = 0;
    int bad = 0;
    req_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .rr_mode_i(rr_mode_i),
        .gnt_o(gnt_o), .gnt_valid_o(gnt_valid_o), .gnt_id_o(gnt_id_o), .timeout_o(timeout_o)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic settle();
        req_i = 4'b0000;
        step();
        step();
    endtask
    initial begin
        rst_n = 1'b0;
        req_i = 4'b0000;
        rr_mode_i = 1'b0;
        step();
        step();
        chk("rst_gnt", 32'(gnt_o), 0);
        chk("rst_valid", 32'(gnt_valid_o), 0);
        chk("rst_id", 32'(gnt_id_o), 0);
        chk("rst_to", 32'(timeout_o), 0);
        rst_n = 1'b1;
        req_i = 4'b1010;
        step();
        chk("fp_gnt", 32'(gnt_o), 32'b0010);
        chk("fp_id", 32'(gnt_id_o), 1);
        chk("fp_valid", 32'(gnt_valid_o), 1);
        req_i = 4'b1000;
        step();
        chk("fp_gap", 32'(gnt_o), 0);
        chk("fp_gap_valid", 32'(gnt_valid_o), 0);
        step();
        chk("fp_gnt3", 32'(gnt_o), 32'b1000);
        chk("fp_id3", 32'(gnt_id_o), 3);
        settle();
        rr_mode_i = 1'b1;
        req_i = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("rr_gnt%0d", n), 32'(gnt_o), 32'(1 << (n % 4)));
            chk($sformatf("rr_id%0d", n), 32'(gnt_id_o), 32'(n % 4));
            step();
            chk($sformatf("rr_hold%0d", n), 32'(gnt_o), 32'(1 << (n % 4)));
            req_i[n % 4] = 1'b0;
            step();
            chk($sformatf("rr_gap%0d", n), 32'(gnt_o), 0);
            req_i = 4'b1111;
        end
        settle();
        rr_mode_i = 1'b0;
        req_i = 4'b0001;
        step();
        chk("to_gnt", 32'(gnt_o), 32'b0001);
        for (int n = 0; n < 7; n++) begin
            step();
            chk($sformatf("to_held%0d", n), {31'(gnt_o), timeout_o}, {31'b0001, 1'b0});
        end
        step();
        chk("to_revoke", 32'(gnt_o), 0);
        chk("to_pulse", 32'(timeout_o), 1);
        step();
        chk("to_holdoff", {31'(gnt_o), timeout_o}, 0);
        step();
        chk("to_masked", 32'(gnt_o), 0);
        step();
        chk("to_regrant", 32'(gnt_o), 32'b0001);
        settle();
        req_i = 4'b0011;
        step();
        chk("tc_gnt0", 32'(gnt_o), 32'b0001);
        for (int n = 0; n < 7; n++) step();
        step();
        chk("tc_pulse", 32'(timeout_o), 1);
        step();
        chk("tc_holdoff", 32'(gnt_o), 0);
        step();
        chk("tc_gnt1", 32'(gnt_o), 32'b0010);
        chk("tc_id1", 32'(gnt_id_o), 1);
        settle();
        req_i = 4'b0001;
        step();
        for (int n = 0; n < 7; n++) step();
        req_i = 4'b0000;
        step();
        chk("sim_gnt", 32'(gnt_o), 0);
        chk("sim_no_to", 32'(timeout_o), 0);
        req_i = 4'b0001;
        step();
        chk("sim_idle_regrant", 32'(gnt_o), 32'b0001);
        settle();
        rr_mode_i = 1'b1;
        req_i = 4'b0100;
        step();
        chk("mr_gnt", 32'(gnt_o), 32'b0100);
        rst_n = 1'b0;
        req_i = 4'b1111;
        step();
        chk("mr_rst", {28'(gnt_o), gnt_valid_o, gnt_id_o, timeout_o}, 0);
        rst_n = 1'b1;
        step();
        chk("mr_rr_restart", 32'(gnt_o), 32'b0001);
        settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
